medidor_ciclo_trabajo: RTL and testbench
========================================

Name: medidor_ciclo_trabajo

Overview:
PWM receiver and duty-cycle decoder. It samples an external PWM waveform, for example the 16-step signal produced by the duty-cycle modifier, and measures its high time and period in clk_100MHz cycles. It converts the ratio to the same 4-bit duty code (0–15, in sixteenths) used by the generator side. It sits on the input side of the board so a received PWM can be displayed or compared against the locally selected duty code.

Parameters:
CNT_W, 20, width of the high-time and period counters (max measurable period 2^CNT_W-1 cycles)
TIMEOUT, 1000000, clk_100MHz cycles without a rising edge before the signal is declared lost (must be < 2^CNT_W)

Ports:
clk_100MHz  input  1  system clock; only clock in the block
rst  input  1  asynchronous, active-high reset
pwm_in  input  1  asynchronous PWM input
en  input  1  measurement enable; when 0 the FSM is held in IDLE and counters are cleared
duty_out  output  4  last decoded duty code, floor(16*high/period), range 0–15
duty_valid  output  1  one-cycle pulse when duty_out is updated
signal_lost  output  1  1 when no rising edge has been seen within TIMEOUT cycles
overrun  output  1  sticky flag: a period ended while the divider was busy; cleared by rst or en=0

Behaviour:
- Interface: one clock, clk_100MHz. rst is asynchronous and active-high.
- Reset values: duty_out=0, duty_valid=0, signal_lost=1, overrun=0, FSM=IDLE, all counters and synchronizer flops=0.
- Synchronization: pwm_in passes through a 2-flop synchronizer, giving s. A third flop gives s_d.
  - Rise = s & ~s_d.
  - All timing is measured on s, so there is a fixed 3-cycle input latency.
- FSM states: IDLE, MEASURE, DIVIDE, UPDATE.
- IDLE: counters cleared. On rise with en=1, go to MEASURE with period_cnt=1 and high_cnt=1.
- MEASURE: each cycle, period_cnt increments. high_cnt increments while s=1.
  - On rise: copy high_cnt to op_h and period_cnt to op_p, restart both counters at 1, go to DIVIDE.
- DIVIDE: restoring divider, exactly 4 cycles, quotient bits MSB first.
  - Each cycle: r = r<<1; if r >= op_p then r = r - op_p and the quotient bit is 1.
  - Initial r = op_h. Width is CNT_W+1. Because op_h < op_p, the result is always 0–15.
  - Measurement counters keep running in parallel.
- UPDATE: duty_out gets the quotient, duty_valid=1 for this cycle only, signal_lost clears, return to MEASURE.
- Latency: duty_valid pulses 6 cycles after the cycle in which rise is detected (1 latch, 4 divide, 1 update).
- Short periods: a rise during DIVIDE or UPDATE discards the in-flight result, sets overrun, and latches the new operands, restarting DIVIDE at bit 3. Valid measurement requires a period of at least 6 cycles.
- Timeout: if period_cnt reaches TIMEOUT in MEASURE (or TIMEOUT cycles pass in IDLE with en=1):
  - signal_lost=1.
  - duty_out = 15 if s=1 (stuck high), 0 if s=0 (stuck low).
  - duty_valid pulses once; go to IDLE.
  - The next rise restarts measurement. The first period after a restart produces a result normally.
- Counter saturation: counters never wrap. TIMEOUT always fires before 2^CNT_W-1.
- en deasserted mid-operation: next cycle FSM=IDLE, counters cleared, any in-progress divide is abandoned with no duty_valid pulse, duty_out and signal_lost hold, overrun clears.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronously).

Optional Feature:
MEDIDOR_PROMEDIO_EN
- Defined: UPDATE outputs duty_out = (prev_q + q + 1) >> 1, where prev_q is the previous quotient, then stores q as prev_q.
  - The first result after reset, timeout or en=0 is output unaveraged.
  - Timeout values (0/15) load prev_q.
- Not defined: duty_out = q directly, and no prev_q register exists.

Test Plan:
- Basic decode: period 160 cycles, high 60, en=1 → from the 2nd rising edge on, duty_valid every 160 cycles and duty_out=6. Check the pulse comes 6 cycles after the synchronized rise.
- Extremes: high 1/period 160 → duty_out=0. High 159/period 160 → duty_out=15. Period 16, high 8 → 8.
- Stuck levels (TIMEOUT=1000 for sim): hold pwm_in=1 after a valid waveform → after 1000 cycles signal_lost=1, duty_out=15, one duty_valid pulse. Repeat with pwm_in=0 → duty_out=0. A restored waveform clears signal_lost on the next result.
- Overrun: period 4 cycles → overrun=1 and no duty_valid pulses. Switch to period 64, high 32 → duty_out=8, overrun stays 1 until en toggled.
- Reset/enable mid-divide: assert rst 2 cycles into DIVIDE → duty_out=0, signal_lost=1, no pulse. Drop en mid-divide → no pulse, duty_out holds previous value.
- With MEDIDOR_PROMEDIO_EN: duty 6 then 9 → outputs 6, then 8.

Source files
------------

// File: rtl/medidor_ciclo_trabajo.sv
// PWM receiver: measures high time and period of pwm_in and decodes floor(16*high/period) as a 4-bit duty code.
// Optional MEDIDOR_PROMEDIO_EN averages each result with the previous quotient before output.
module medidor_ciclo_trabajo #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       pwm_in,
    input  logic       en,
    output logic [3:0] duty_out,
    output logic       duty_valid,
    output logic       signal_lost,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, UPDATE} state_t;

    localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic             r_sync1;
    logic             r_s;
    logic             r_s_d;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_op_p;
    logic [CNT_W-1:0] r_rem;
    logic [3:0]       r_quot;
    logic [1:0]       r_bit;
`ifdef MEDIDOR_PROMEDIO_EN
    logic [3:0]       r_prev_q;
    logic             r_have_prev;
`endif

    logic             w_rise;
    logic [CNT_W-1:0] w_period_inc;
    logic [CNT_W-1:0] w_high_next;
    logic [CNT_W:0]   w_shift;
    logic             w_ge;
    logic [CNT_W-1:0] w_sub;
    logic [3:0]       w_stuck;
    logic [3:0]       w_result;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
        end
    end

    assign w_rise       = r_s & ~r_s_d;
    assign w_period_inc = (r_period_cnt == CNT_MAX) ? r_period_cnt : r_period_cnt + 1'b1;
    assign w_high_next  = (r_s && (r_high_cnt != CNT_MAX)) ? r_high_cnt + 1'b1 : r_high_cnt;
    assign w_stuck      = r_s ? 4'd15 : 4'd0;

    // The remainder stays below op_p, so it fits in CNT_W bits; only the shifted value needs the extra bit.
    assign w_shift = {r_rem, 1'b0};
    assign w_ge    = (w_shift >= {1'b0, r_op_p});
    assign w_sub   = CNT_W'(w_shift - {1'b0, r_op_p});

`ifdef MEDIDOR_PROMEDIO_EN
    assign w_result = r_have_prev ? 4'((5'(r_prev_q) + 5'(r_quot) + 5'd1) >> 1) : r_quot;
`else
    assign w_result = r_quot;
`endif

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_op_p       <= '0;
            r_rem        <= '0;
            r_quot       <= 4'd0;
            r_bit        <= 2'd0;
            duty_out     <= 4'd0;
            duty_valid   <= 1'b0;
            signal_lost  <= 1'b1;
            overrun      <= 1'b0;
`ifdef MEDIDOR_PROMEDIO_EN
            r_prev_q     <= 4'd0;
            r_have_prev  <= 1'b0;
`endif
        end else begin
            duty_valid <= 1'b0;
            if (!en) begin
                r_state      <= IDLE;
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
                r_idle_cnt   <= '0;
                overrun      <= 1'b0;
`ifdef MEDIDOR_PROMEDIO_EN
                r_have_prev  <= 1'b0;
`endif
            end else if (r_state == IDLE) begin
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
                if (w_rise) begin
                    r_state      <= MEASURE;
                    r_period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                    r_high_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                    r_idle_cnt   <= '0;
                // A saturated idle count means loss was already declared, so a dead input pulses only once.
                end else if (r_idle_cnt != TO) begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                    if (r_idle_cnt == TO_M1) begin
                        signal_lost <= 1'b1;
                        duty_out    <= w_stuck;
                        duty_valid  <= 1'b1;
`ifdef MEDIDOR_PROMEDIO_EN
                        r_prev_q    <= w_stuck;
                        r_have_prev <= 1'b0;
`endif
                    end
                end
            end else if (w_rise) begin
                r_state      <= DIVIDE;
                r_op_p       <= r_period_cnt;
                r_rem        <= r_high_cnt;
                r_quot       <= 4'd0;
                r_bit        <= 2'd3;
                r_period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                r_high_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_state != MEASURE) begin
                    overrun <= 1'b1;
                end
            end else begin
                r_period_cnt <= w_period_inc;
                r_high_cnt   <= w_high_next;
                case (r_state)
                    MEASURE: begin
                        if (r_period_cnt == TO) begin
                            r_state      <= IDLE;
                            r_period_cnt <= '0;
                            r_high_cnt   <= '0;
                            r_idle_cnt   <= TO;
                            signal_lost  <= 1'b1;
                            duty_out     <= w_stuck;
                            duty_valid   <= 1'b1;
`ifdef MEDIDOR_PROMEDIO_EN
                            r_prev_q     <= w_stuck;
                            r_have_prev  <= 1'b0;
`endif
                        end
                    end
                    DIVIDE: begin
                        r_rem         <= w_ge ? w_sub : w_shift[CNT_W-1:0];
                        r_quot[r_bit] <= w_ge;
                        if (r_bit == 2'd0) begin
                            r_state <= UPDATE;
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                    UPDATE: begin
                        r_state     <= MEASURE;
                        duty_out    <= w_result;
                        duty_valid  <= 1'b1;
                        signal_lost <= 1'b0;
`ifdef MEDIDOR_PROMEDIO_EN
                        r_prev_q    <= r_quot;
                        r_have_prev <= 1'b1;
`endif
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_medidor_ciclo_trabajo.sv
// Bench for medidor_ciclo_trabajo: directed PWM patterns checked every cycle against an edge/ratio model.
// Honours MEDIDOR_PROMEDIO_EN when the design is built with it.
module tb_medidor_ciclo_trabajo;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 1000;

    logic       clk_100MHz = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic       en;
    logic [3:0] duty_out;
    logic       duty_valid;
    logic       signal_lost;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulseCnt = 0;
    int lastPulseCyc = -1;
    int riseDriveCyc = 0;

    // Model state: results are ratios of edge-to-edge times, delivered a fixed delay after the edge.
    bit dl1, dl2, dl3, mS, mRise;
    bit active, pendOn, idleFired, havePrev;
    int riseCyc, highCnt, pendVal, pendDue, idleCnt, prevQ;
    int expDuty, expValid, expLost, expOver;

    medidor_ciclo_trabajo #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .en         (en),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .signal_lost(signal_lost),
        .overrun    (overrun)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic declareLost();
        expLost  = 1;
        expDuty  = mS ? 15 : 0;
        expValid = 1;
        prevQ    = expDuty;
        havePrev = 0;
    endtask

    always @(posedge clk_100MHz) begin
        cyc++;
        if (rst) begin
            dl1 = 0; dl2 = 0; dl3 = 0;
            active = 0; pendOn = 0; idleFired = 0; havePrev = 0;
            idleCnt = 0; prevQ = 0;
            expDuty = 0; expValid = 0; expLost = 1; expOver = 0;
        end else begin
            mS    = dl2;
            mRise = dl2 & ~dl3;
            dl3 = dl2; dl2 = dl1; dl1 = pwm_in;
            expValid = 0;
            if (!en) begin
                active = 0; pendOn = 0; expOver = 0;
                idleCnt = 0; idleFired = 0; havePrev = 0;
            end else if (!active) begin
                if (mRise) begin
                    active = 1; riseCyc = cyc; highCnt = 1;
                    idleCnt = 0; idleFired = 0;
                end else if (!idleFired) begin
                    idleCnt++;
                    if (idleCnt == TIMEOUT) begin
                        declareLost();
                        idleFired = 1;
                    end
                end
            end else if (mRise) begin
                if (pendOn) expOver = 1;
                pendOn  = 1;
                pendVal = (16 * highCnt) / (cyc - riseCyc);
                pendDue = cyc + 5;
                riseCyc = cyc;
                highCnt = 1;
            end else begin
                if (pendOn && cyc == pendDue) begin
`ifdef MEDIDOR_PROMEDIO_EN
                    expDuty  = havePrev ? (prevQ + pendVal + 1) / 2 : pendVal;
                    prevQ    = pendVal;
                    havePrev = 1;
`else
                    expDuty  = pendVal;
`endif
                    expValid = 1;
                    expLost  = 0;
                    pendOn   = 0;
                end
                if (cyc - riseCyc == TIMEOUT) begin
                    declareLost();
                    active = 0;
                    idleFired = 1;
                end else if (mS) begin
                    highCnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_100MHz);
            #1;
            checkOutput("duty_out", duty_out, expDuty);
            checkOutput("duty_valid", duty_valid, expValid);
            checkOutput("signal_lost", signal_lost, expLost);
            checkOutput("overrun", overrun, expOver);
            if (duty_valid) begin
                pulseCnt++;
                lastPulseCyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input int period, input int high, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < period; i++) begin
                @(negedge clk_100MHz);
                if (i == 0) riseDriveCyc = cyc;
                pwm_in = (i < high);
            end
        end
    endtask

    task automatic holdLevel(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100MHz);
            pwm_in = lvl;
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        checkOutput("rst_duty", duty_out, 0);
        checkOutput("rst_lost", signal_lost, 1);
        checkOutput("rst_valid", duty_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        rst = 1'b0;
        en = 1'b1;
        holdLevel(0, 3);

        pulseCnt = 0;
        applyStimulus(160, 60, 4);
        checkOutput("basic_duty", duty_out, 6);
        checkOutput("basic_pulses", pulseCnt, 3);
        checkOutput("basic_latency", lastPulseCyc, riseDriveCyc + 8);
        checkOutput("basic_lost", signal_lost, 0);

        applyStimulus(160, 1, 3);
        checkOutput("min_duty", duty_out, 0);
        applyStimulus(160, 159, 3);
        checkOutput("max_duty", duty_out, 15);
        applyStimulus(16, 8, 4);
        checkOutput("p16_duty", duty_out, 8);

        holdLevel(1, 20);
        pulseCnt = 0;
        holdLevel(1, 1080);
        checkOutput("stuckhi_pulses", pulseCnt, 1);
        checkOutput("stuckhi_duty", duty_out, 15);
        checkOutput("stuckhi_lost", signal_lost, 1);

        holdLevel(0, 4);
        applyStimulus(64, 32, 3);
        checkOutput("restore_lost", signal_lost, 0);
        checkOutput("restore_duty", duty_out, 8);

        pulseCnt = 0;
        holdLevel(0, 1100);
        checkOutput("stucklo_pulses", pulseCnt, 1);
        checkOutput("stucklo_duty", duty_out, 0);
        checkOutput("stucklo_lost", signal_lost, 1);

        pulseCnt = 0;
        applyStimulus(4, 2, 20);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_pulses", pulseCnt, 0);
        applyStimulus(64, 32, 3);
        checkOutput("ovr_duty", duty_out, 8);
        checkOutput("ovr_sticky", overrun, 1);
        en = 1'b0;
        holdLevel(0, 3);
        checkOutput("en_clr_ovr", overrun, 0);
        checkOutput("en_hold_duty", duty_out, 8);
        en = 1'b1;

        holdLevel(0, 4);
        applyStimulus(64, 32, 1);
        pulseCnt = 0;
        holdLevel(1, 1);
        holdLevel(1, 5);
        rst = 1'b1;
        #1;
        checkOutput("rstdiv_duty", duty_out, 0);
        checkOutput("rstdiv_lost", signal_lost, 1);
        checkOutput("rstdiv_valid", duty_valid, 0);
        holdLevel(1, 3);
        rst = 1'b0;
        pwm_in = 1'b0;
        holdLevel(0, 10);
        checkOutput("rstdiv_pulses", pulseCnt, 0);

        applyStimulus(64, 32, 2);
        applyStimulus(64, 16, 1);
        checkOutput("endiv_pre", duty_out, 8);
        pulseCnt = 0;
        holdLevel(1, 1);
        holdLevel(1, 5);
        en = 1'b0;
        holdLevel(0, 10);
        checkOutput("endiv_pulses", pulseCnt, 0);
        checkOutput("endiv_duty", duty_out, 8);
        checkOutput("endiv_lost", signal_lost, 0);
        en = 1'b1;

        holdLevel(0, 4);
        applyStimulus(64, 48, 3);
        checkOutput("d12_duty", duty_out, 12);
        applyStimulus(64, 24, 2);
        applyStimulus(64, 36, 1);
        checkOutput("d6_duty", duty_out, 6);
        holdLevel(1, 20);
`ifdef MEDIDOR_PROMEDIO_EN
        checkOutput("avg_6_9", duty_out, 8);
`else
        checkOutput("d9_duty", duty_out, 9);
`endif
        holdLevel(0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
